controle_jogo: RTL

CONTROLE_JOGO -- requirements
Module: controle_jogo

---
 rtl/controle_jogo_if.sv | 24 ++
 rtl/controle_jogo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/controle_jogo_if.sv
// Player/comparator bus for controle_jogo: guess inputs, comparator verdict and game status.
interface controle_jogo_if;
    logic [3:0] entrada;
    logic       confirma;
    logic       reiniciar;
    logic [1:0] resultado;
    logic [3:0] tentativaA;
    logic [2:0] tentativaB;
    logic       modoB;
    logic [1:0] dica;
    logic [3:0] erros;
    logic       vitoria;
    logic       bloqueado;

    modport master (
        output entrada, confirma, reiniciar, resultado,
        input  tentativaA, tentativaB, modoB, dica, erros, vitoria, bloqueado
    );

    modport slave (
        input  entrada, confirma, reiniciar, resultado,
        output tentativaA, tentativaB, modoB, dica, erros, vitoria, bloqueado
    );
endinterface

// File: rtl/controle_jogo.sv
// Two-phase guessing game controller driving an external comparator.
// Define BLOQUEIO_EN to add the timed lockout after MAX_TENT wrong guesses.
module controle_jogo #(
    parameter int unsigned MAX_TENT   = 5,
    parameter int unsigned TEMPO_BLOQ = 16
) (
    input logic              clk,
    input logic              rst_n,
    controle_jogo_if.slave   bus
);

`ifdef BLOQUEIO_EN
    typedef enum logic [2:0] {
        StEsperaA, StComparaA, StEsperaB, StComparaB, StVitoria, StBloqueio
    } state_e;
    localparam logic [7:0] TempoCarga = 8'(TEMPO_BLOQ - 1);
    logic [7:0] timer_q, timer_d;
`else
    typedef enum logic [2:0] {
        StEsperaA, StComparaA, StEsperaB, StComparaB, StVitoria
    } state_e;
    logic unused_cfg;
    assign unused_cfg = ^{MAX_TENT, TEMPO_BLOQ};
`endif

    localparam logic [1:0] ResIgual = 2'b10;

    state_e     state_q, state_d;
    logic [3:0] tent_a_q, tent_a_d;
    logic [2:0] tent_b_q, tent_b_d;
    logic       modo_b_q, modo_b_d;
    logic [1:0] dica_q, dica_d;
    logic [3:0] erros_q, erros_d;
    logic [3:0] erros_inc;

    assign erros_inc = (erros_q == 4'hF) ? erros_q : erros_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEsperaA;
            tent_a_q <= '0;
            tent_b_q <= '0;
            modo_b_q <= 1'b0;
            dica_q   <= '0;
            erros_q  <= '0;
`ifdef BLOQUEIO_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tent_a_q <= tent_a_d;
            tent_b_q <= tent_b_d;
            modo_b_q <= modo_b_d;
            dica_q   <= dica_d;
            erros_q  <= erros_d;
`ifdef BLOQUEIO_EN
            timer_q  <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        tent_a_d = tent_a_q;
        tent_b_d = tent_b_q;
        modo_b_d = modo_b_q;
        dica_d   = dica_q;
        erros_d  = erros_q;
`ifdef BLOQUEIO_EN
        timer_d  = timer_q;
`endif
        // Restart beats both a pending guess and the lockout timer.
        if (bus.reiniciar) begin
            state_d  = StEsperaA;
            tent_a_d = '0;
            tent_b_d = '0;
            modo_b_d = 1'b0;
            dica_d   = '0;
            erros_d  = '0;
`ifdef BLOQUEIO_EN
            timer_d  = '0;
`endif
        end else begin
            case (state_q)
                StEsperaA: begin
                    if (bus.confirma) begin
                        tent_a_d = bus.entrada;
                        state_d  = StComparaA;
                    end
                end
                StEsperaB: begin
                    if (bus.confirma) begin
                        tent_b_d = bus.entrada[2:0];
                        state_d  = StComparaB;
                    end
                end
                StComparaA, StComparaB: begin
                    if (bus.resultado == ResIgual) begin
                        if (state_q == StComparaA) begin
                            state_d  = StEsperaB;
                            modo_b_d = 1'b1;
                            dica_d   = '0;
                        end else begin
                            state_d = StVitoria;
                        end
                    end else begin
                        dica_d  = bus.resultado;
                        erros_d = erros_inc;
                        state_d = (state_q == StComparaA) ? StEsperaA : StEsperaB;
`ifdef BLOQUEIO_EN
                        if (erros_inc == MAX_TENT[3:0]) begin
                            state_d = StBloqueio;
                            timer_d = TempoCarga;
                        end
`endif
                    end
                end
                StVitoria: ;
`ifdef BLOQUEIO_EN
                StBloqueio: begin
                    if (timer_q == '0) begin
                        state_d  = StEsperaA;
                        tent_a_d = '0;
                        tent_b_d = '0;
                        modo_b_d = 1'b0;
                        dica_d   = '0;
                        erros_d  = '0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
`endif
                default: state_d = StEsperaA;
            endcase
        end
    end

    assign bus.tentativaA = tent_a_q;
    assign bus.tentativaB = tent_b_q;
    assign bus.modoB      = modo_b_q;
    assign bus.dica       = dica_q;
    assign bus.erros      = erros_q;
    assign bus.vitoria    = (state_q == StVitoria);
`ifdef BLOQUEIO_EN
    assign bus.bloqueado  = (state_q == StBloqueio);
`else
    assign bus.bloqueado  = 1'b0;
`endif

endmodule
